alu_input_sequencer: RTL

- Front-end stage directly upstream of the 8-bit ALU.
- Loads A, B, then OP from the board slide switches (SW) on successive debounced presses of one pushbutton, and drives them as registered ALU operands.
- After OP is loaded, captures the ALU's combinational Y and C/V/N/Z back into a result register.
- Turns the combinational ALU into a step-by-step board demo with stable, held results.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/key_debouncer.sv | 48 ++++
 rtl/alu_input_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU front-end: FSM state encoding,
// datapath widths and the captured-flags layout.
package alu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned STATE_W = 3;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [STATE_W-1:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  // Field order matches the FLAGS bus: bit 3 = C down to bit 0 = Z.
  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/key_debouncer.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on a debounced high-to-low transition.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_l,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             synced;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // A level is accepted only after it differs from 'stable' for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      synced   <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= key_l;
      synced   <= sync1;
      stable_d <= stable;
      press    <= stable_d & ~stable;
      if (synced != stable) begin
        if (cnt == CNT_MAX) begin
          stable <= synced;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_input_sequencer.sv
// Step-by-step ALU front-end: loads A, B and OP from the switches on
// successive key presses, then captures the ALU result and flags.
module alu_input_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [DATA_W-1:0]   SW,
  input  logic                KEY_L,
  output logic [DATA_W-1:0]   A,
  output logic [DATA_W-1:0]   B,
  output logic [OP_W-1:0]     OP,
  input  logic [DATA_W-1:0]   Y_IN,
  input  logic                C_IN,
  input  logic                V_IN,
  input  logic                N_IN,
  input  logic                Z_IN,
  output logic [DATA_W-1:0]   RESULT,
  output logic [FLAG_W-1:0]   FLAGS,
  output logic [STATE_W-1:0]  STATE,
  output logic                VALID
);

  state_t state_q;
  state_t state_d;
  logic   press;
  logic   load_a_c;
  logic   load_b_c;
  logic   load_op_c;
  logic   capture_c;
  logic   clr_valid_c;
  flags_t flags_in_c;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk  (CLK),
    .rst  (RESET),
    .key_l(KEY_L),
    .press(press)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_LOAD_A;
    else       state_q <= state_d;
  end

  // Only the press pulse advances the load states; EXEC always falls through.
  always_comb begin
    state_d = S_LOAD_A;
    case (state_q)
      S_LOAD_A:  state_d = press ? S_LOAD_B  : S_LOAD_A;
      S_LOAD_B:  state_d = press ? S_LOAD_OP : S_LOAD_B;
      S_LOAD_OP: state_d = press ? S_EXEC    : S_LOAD_OP;
      S_EXEC:    state_d = S_SHOW;
      S_SHOW:    state_d = press ? S_LOAD_A  : S_SHOW;
      default:   state_d = S_LOAD_A;
    endcase
  end

  always_comb begin
    load_a_c    = 1'b0;
    load_b_c    = 1'b0;
    load_op_c   = 1'b0;
    capture_c   = 1'b0;
    clr_valid_c = 1'b0;
    case (state_q)
      S_LOAD_A: begin
        load_a_c    = press;
        clr_valid_c = 1'b1;
      end
      S_LOAD_B:  load_b_c    = press;
      S_LOAD_OP: load_op_c   = press;
      S_EXEC:    capture_c   = 1'b1;
      S_SHOW:    clr_valid_c = press;
      default:   clr_valid_c = 1'b1;
    endcase
  end

  assign flags_in_c = '{c: C_IN, v: V_IN, n: N_IN, z: Z_IN};

  // Operand and result registers; RESULT is kept on wrap and flagged stale by VALID.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      A      <= '0;
      B      <= '0;
      OP     <= '0;
      RESULT <= '0;
      FLAGS  <= '0;
      VALID  <= 1'b0;
    end else begin
      if (load_a_c)  A  <= SW;
      if (load_b_c)  B  <= SW;
      if (load_op_c) OP <= SW[OP_W-1:0];
      if (capture_c) begin
        RESULT <= Y_IN;
        FLAGS  <= flags_in_c;
        VALID  <= 1'b1;
      end else if (clr_valid_c) begin
        VALID <= 1'b0;
      end
    end
  end

  assign STATE = state_q;

endmodule
